// File: rtl/arbitro_mux_41_pkg.sv
// arbitro_mux_41_pkg: shared state encoding and channel constants for the 4-channel mux arbiter.
package arbitro_mux_41_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
   localparam int NCH   = 4;
   localparam int IDX_W = 2;
endpackage

// File: rtl/arbitro_mux_41_rr_pick.sv
// rr_pick_4: combinational round-robin pick; first unmasked request at or after ptr, modulo 4.
module rr_pick_4
   import arbitro_mux_41_pkg::*;
(
   input  logic [NCH-1:0]   req,
   input  logic [NCH-1:0]   mask,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);
   logic [NCH-1:0]   cand;
   logic [2*NCH-1:0] dbl;
   logic [NCH-1:0]   rot;
   logic [IDX_W-1:0] off;
   assign cand  = req & ~mask;
   assign dbl   = {cand, cand} >> ptr;
   assign rot   = dbl[NCH-1:0];
   assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
   assign found = |cand;
   assign idx   = ptr + off;
endmodule

// File: rtl/arbitro_mux_41.sv
// arbitro_mux_41: round-robin arbiter driving the select lines of a 4:1 mux with a bounded hold time.
// Define ARB41_LOCK_EN to add a lock input that suspends the hold limit.
module arbitro_mux_41
   import arbitro_mux_41_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 8
)(
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req,
   input  logic           done,
`ifdef ARB41_LOCK_EN
   input  logic           lock,
`endif
   output logic [NCH-1:0] gnt,
   output logic           sel_a,
   output logic           sel_b,
   output logic           busy
);
   state_t           state_q;
   logic [NCH-1:0]   gnt_q;
   logic [IDX_W-1:0] sel_q;
   logic             busy_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             hit, expire, rel, found;
   logic [IDX_W-1:0] idx, pick_ptr;
   logic [NCH-1:0]   pick_mask;
   assign hit = cnt_q == CNT_W'(HOLD_MAX - 1);
`ifdef ARB41_LOCK_EN
   assign expire = hit & ~lock;
`else
   assign expire = hit;
`endif
   assign rel = done | ~req[sel_q] | expire;
   // The owner is masked and the scan starts just past it, so a released owner cannot re-win immediately.
   assign pick_mask = (state_q == GRANT) ? (NCH'(1) << sel_q) : '0;
   assign pick_ptr  = (state_q == GRANT) ? sel_q + 2'd1 : rr_ptr_q;
   rr_pick_4 u_pick (
      .req   (req),
      .mask  (pick_mask),
      .ptr   (pick_ptr),
      .found (found),
      .idx   (idx)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (state_q == IDLE) begin
         if (found) begin
            gnt_q   <= NCH'(1) << idx;
            sel_q   <= idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= GRANT;
         end
      end else if (!rel) begin
         cnt_q <= hit ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
         rr_ptr_q <= sel_q + 2'd1;
         cnt_q    <= '0;
         if (found) begin
            gnt_q <= NCH'(1) << idx;
            sel_q <= idx;
         end else begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
         end
      end
   end
   assign gnt   = gnt_q;
   assign sel_a = sel_q[1];
   assign sel_b = sel_q[0];
   assign busy  = busy_q;
endmodule

// File: tb/tb_arbitro_mux_41.sv
// tb_arbitro_mux_41: directed scoreboard bench for arbitro_mux_41 with default HOLD_MAX=8.
module tb_arbitro_mux_41;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       done = 1'b0;
   logic [3:0] req = 4'b0000;
`ifdef ARB41_LOCK_EN
   logic       lock = 1'b0;
`endif
   logic [3:0] gnt;
   logic       sel_a, sel_b, busy;
   int         errors = 0;
   int         checks = 0;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] s;
      logic       b;
   } exp_t;

   exp_t  sb[$];
   string tags[$];

   arbitro_mux_41 dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .done  (done),
`ifdef ARB41_LOCK_EN
      .lock  (lock),
`endif
      .gnt   (gnt),
      .sel_a (sel_a),
      .sel_b (sel_b),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_done,
                       input logic [3:0] eg, input logic [1:0] es, input logic eb, input string tag);
      exp_t  e, o;
      string t;
      @(negedge clk);
      rst  = r_rst;
      req  = r_req;
      done = r_done;
      sb.push_back(exp_t'({eg, es, eb}));
      tags.push_back(tag);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      t = tags.pop_front();
      o = exp_t'({gnt, sel_a, sel_b, busy});
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: got gnt=%b sel=%b busy=%b want gnt=%b sel=%b busy=%b",
                t, o.g, o.s, o.b, e.g, e.s, e.b);
      end
   endtask

   initial begin
      // reset with requests pending must still yield reset values
      step(1, 4'b1111, 1, 4'b0000, 2'b00, 0, "reset");
      step(1, 4'b0100, 0, 4'b0000, 2'b00, 0, "reset_hold");
      // single request, one-cycle latency
      step(0, 4'b0100, 0, 4'b0100, 2'b10, 1, "grant_ch2");
      step(0, 4'b0100, 0, 4'b0100, 2'b10, 1, "hold_ch2");
      // owner drops with no other requester: idle, selects unchanged
      step(0, 4'b0000, 0, 4'b0000, 2'b10, 0, "drop_idle");
      step(0, 4'b0000, 0, 4'b0000, 2'b10, 0, "stay_idle");
      // rr_ptr is now 3, so channel 3 wins first from idle
      step(0, 4'b1001, 0, 4'b1000, 2'b11, 1, "ptr_after_idle");
      step(0, 4'b0000, 0, 4'b0000, 2'b11, 0, "drop_idle2");
      // full rotation, 8 cycles per grant, back-to-back
      step(1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset_rot");
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 8; c++)
            step(0, 4'b1111, 0, 4'b0001 << (r % 4), 2'(r % 4), 1, "rotate");
      // done together with hold expiry advances the pointer only once
      step(1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset_dx");
      for (int c = 0; c < 8; c++)
         step(0, 4'b1111, 0, 4'b0001, 2'b00, 1, "dx_ch0");
      step(0, 4'b1111, 1, 4'b0010, 2'b01, 1, "dx_release");
      step(0, 4'b1111, 0, 4'b0010, 2'b01, 1, "dx_single_adv");
      // done on owner 1 wraps to channel 0, not back to 1
      step(1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset_wrap");
      step(0, 4'b0010, 0, 4'b0010, 2'b01, 1, "grant_ch1");
      step(0, 4'b0011, 0, 4'b0010, 2'b01, 1, "ch1_c1");
      step(0, 4'b0011, 0, 4'b0010, 2'b01, 1, "ch1_c2");
      step(0, 4'b0011, 1, 4'b0001, 2'b00, 1, "done_wrap_ch0");
      step(0, 4'b0011, 0, 4'b0001, 2'b00, 1, "ch0_hold");
      step(0, 4'b0011, 1, 4'b0010, 2'b01, 1, "done_to_ch1");
      // masked owner still requesting goes idle before re-winning
      step(0, 4'b0010, 1, 4'b0000, 2'b01, 0, "masked_idle");
      step(0, 4'b0010, 0, 4'b0010, 2'b01, 1, "rewin_ch1");
      // reset mid-grant on channel 3
      step(1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset_mid");
      step(0, 4'b1000, 0, 4'b1000, 2'b11, 1, "grant_ch3");
      step(0, 4'b1000, 0, 4'b1000, 2'b11, 1, "hold_ch3");
      step(1, 4'b1000, 0, 4'b0000, 2'b00, 0, "reset_in_grant");
      step(0, 4'b1111, 0, 4'b0001, 2'b00, 1, "post_reset_ch0");
`ifdef ARB41_LOCK_EN
      step(1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset_lock");
      lock = 1'b1;
      for (int c = 0; c < 12; c++)
         step(0, 4'b1111, 0, 4'b0001, 2'b00, 1, "lock_hold");
      step(0, 4'b1111, 1, 4'b0010, 2'b01, 1, "lock_done");
      lock = 1'b0;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/arbitro_mux_41.md
Name: arbitro_mux_41

Overview:
- Round-robin arbiter and sequencer for the 4-channel multiplexer. It shares one mux output among four requesters.
- Registered select bits drive the mux: sel_a goes to select A (MSB) and sel_b to select B (LSB). A one-hot grant tells the winning requester that its channel is routed.
- Each grant lasts until the owner releases it or a hold limit expires. This bounds latency for the other channels.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one grant may last (legal range 1..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock; every register updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  request per channel; req[i] asks for mux input Ii.
- done  input  1  current owner releases the grant this cycle.
- gnt  output  4  one-hot grant; all zero when idle.
- sel_a  output  1  mux select A (MSB of the channel index).
- sel_b  output  1  mux select B (LSB of the channel index).
- busy  output  1  high while a grant is active.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. While rst=1 at a rising edge, every register takes its reset value, whatever the other inputs are.
- Reset values: gnt=4'b0000, sel_a=0, sel_b=0, busy=0, state=IDLE, rr_ptr=0, hold counter=0.
- Channel mapping: index = {sel_a,sel_b}. 00 selects I0, 01 selects I1, 10 selects I2, 11 selects I3.
- State IDLE:
  - If req is nonzero at edge k, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - After edge k: gnt=onehot(winner), {sel_a,sel_b}=winner, busy=1, counter=0, state=GRANT.
  - Latency from request to grant is 1 cycle.
- State GRANT, at each edge:
  - Release condition: done=1, OR req[owner]=0, OR counter==HOLD_MAX-1.
  - If no release: counter increments and the grant holds.
  - On release: rr_ptr=(owner+1) mod 4. Arbitration over req, with owner masked out, starts from the new rr_ptr.
  - If any other channel requests, it is granted at the same edge (back-to-back, no idle cycle). The counter resets and the state stays GRANT.
  - Otherwise gnt=0, busy=0, state=IDLE.
  - A masked-out owner that still requests may win again only after it passes through IDLE.
- Select bits hold their last value while idle, so the mux output does not glitch. Only gnt/busy indicate validity.
- HOLD_MAX=1: every grant lasts exactly one cycle, which gives pure per-cycle round-robin.
- Simultaneous done and hold expiry form a single release and do not produce a double pointer advance.
- Reset during GRANT: the grant is dropped at that edge, rr_ptr returns to 0, and no partial count survives.
- Invariant: gnt is always one-hot or zero, and gnt==onehot({sel_a,sel_b}) whenever busy=1.

Optional Feature:
- Macro: ARB41_LOCK_EN.
- Defined: adds input lock (1 bit). While lock=1 in GRANT, hold-limit expiry is ignored. done or req[owner]=0 still release the grant. The counter saturates at HOLD_MAX-1.
- Not defined: the port does not exist and the hold limit always applies.

Decomposition:
- Shared package/include holds:
  - State encodings IDLE=1'b0, GRANT=1'b1.
  - Constant NCH=4.
  - Channel index width 2.
- One natural sub-module, rr_pick_4, is purely combinational:
  - Inputs: req[3:0], mask[3:0], ptr[1:0].
  - Outputs: found and idx[1:0] (rotate, priority-encode, un-rotate).
  - Used for both IDLE and back-to-back arbitration.
- The top level keeps the FSM, counter, pointer and output registers.

Test Plan:
- Reset, then req=4'b0100 held at edge 1 -> after edge 1: gnt=0100, sel_a=1, sel_b=0, busy=1.
- req=4'b1111 held continuously, done=0, HOLD_MAX=8 -> grants rotate 0001,0010,0100,1000,0001; each lasts exactly 8 cycles with no idle cycle between.
- Owner 1 granted, done pulse at cycle 3, req=4'b0011 -> owner 1 releases; the next grant goes to channel 0 (wrap), not channel 1.
- Owner drops req with no other requests -> next edge: gnt=0000, busy=0, {sel_a,sel_b} unchanged.
- rst=1 asserted mid-grant on channel 3 -> next edge: all outputs at reset values; with req=1111 after that, the first grant goes to channel 0.
- ARB41_LOCK_EN defined, lock=1, req=1111 -> channel 0 holds beyond 8 cycles until done=1, then channel 1 is granted.
